// File: rtl/matrix_pkg.sv
// Shared definitions for the MatrixMath command front end.
//
// Contents:
//   ELEM_W         - matrix element width in bits
//   OP_*           - command opcodes recognised by matrix_cmd_loader
//   loader_state_t - loader FSM state encoding
//
// Build option: MATRIX_CMD_CHECKSUM_EN adds the checksum state ST_CHK.
package matrix_pkg;

    localparam int unsigned ELEM_W = 8;

    localparam logic [7:0] OP_LOAD_A = 8'hCA;
    localparam logic [7:0] OP_LOAD_B = 8'hCB;
    localparam logic [7:0] OP_START  = 8'hBB;
    localparam logic [7:0] OP_CLEAR  = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
`ifdef MATRIX_CMD_CHECKSUM_EN
        ST_CHK,
`endif
        ST_START
    } loader_state_t;

endpackage

// File: rtl/matrix_cmd_loader.sv
// Byte-stream command loader for the MatrixMath core.
//
// Decodes opcodes from an 8-bit valid/ready stream, assembles matrices A and
// B (row-major, element k at bits [8k+7:8k]) and issues a one-cycle start
// pulse. op_busy from the core back-pressures the stream.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   in_data/in_valid - command/operand byte and its valid flag
//   in_ready         - byte accepted when in_valid & in_ready
//   op_busy          - MatrixMath busy; stalls byte acceptance
//   mat_a, mat_b     - assembled operand matrices
//   a_valid, b_valid - matrix fully loaded
//   op_start         - one-cycle start pulse to MatrixMath
//   err              - sticky protocol error, cleared by 0xEE or rst
//
// Build option: MATRIX_CMD_CHECKSUM_EN - each load is followed by an XOR
// checksum byte that must match before the matrix is marked valid.
module matrix_cmd_loader
    import matrix_pkg::*;
#(
    parameter int unsigned DIM = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         op_busy,
    output logic [ELEM_W*DIM*DIM-1:0]    mat_a,
    output logic [ELEM_W*DIM*DIM-1:0]    mat_b,
    output logic                         a_valid,
    output logic                         b_valid,
    output logic                         op_start,
    output logic                         err
);

    localparam int unsigned N     = DIM * DIM;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    loader_state_t      state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_elem;
`ifdef MATRIX_CMD_CHECKSUM_EN
    logic [ELEM_W-1:0]  csum;
    logic               chk_b;   // checksum belongs to matrix B
`endif

    assign in_ready  = !rst && !op_busy && (state != ST_START);
    assign accept    = in_valid && in_ready;
    assign last_elem = (cnt == CNT_W'(N - 1));

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (in_data)
                        OP_LOAD_A: next_state = ST_LOAD_A;
                        OP_LOAD_B: next_state = ST_LOAD_B;
                        OP_START:  if (a_valid && b_valid) next_state = ST_START;
                        default:   next_state = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD_A, ST_LOAD_B: begin
                if (accept && last_elem) begin
`ifdef MATRIX_CMD_CHECKSUM_EN
                    next_state = ST_CHK;
`else
                    next_state = ST_IDLE;
`endif
                end
            end
`ifdef MATRIX_CMD_CHECKSUM_EN
            ST_CHK:   if (accept) next_state = ST_IDLE;
`endif
            ST_START: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            mat_a    <= '0;
            mat_b    <= '0;
            a_valid  <= 1'b0;
            b_valid  <= 1'b0;
            op_start <= 1'b0;
            err      <= 1'b0;
`ifdef MATRIX_CMD_CHECKSUM_EN
            csum     <= '0;
            chk_b    <= 1'b0;
`endif
        end else begin
            // START is only ever entered from IDLE on a granted 0xBB
            op_start <= (next_state == ST_START);
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        case (in_data)
                            OP_LOAD_A: begin
                                a_valid <= 1'b0;
                                cnt     <= '0;
`ifdef MATRIX_CMD_CHECKSUM_EN
                                csum    <= '0;
                                chk_b   <= 1'b0;
`endif
                            end
                            OP_LOAD_B: begin
                                b_valid <= 1'b0;
                                cnt     <= '0;
`ifdef MATRIX_CMD_CHECKSUM_EN
                                csum    <= '0;
                                chk_b   <= 1'b1;
`endif
                            end
                            OP_START: begin
                                if (!(a_valid && b_valid)) err <= 1'b1;
                            end
                            OP_CLEAR: begin
                                mat_a   <= '0;
                                mat_b   <= '0;
                                a_valid <= 1'b0;
                                b_valid <= 1'b0;
                                err     <= 1'b0;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                    ST_LOAD_A: begin
                        mat_a[cnt*ELEM_W +: ELEM_W] <= in_data;
                        cnt <= cnt + 1'b1;
`ifdef MATRIX_CMD_CHECKSUM_EN
                        csum <= csum ^ in_data;
`else
                        if (last_elem) a_valid <= 1'b1;
`endif
                    end
                    ST_LOAD_B: begin
                        mat_b[cnt*ELEM_W +: ELEM_W] <= in_data;
                        cnt <= cnt + 1'b1;
`ifdef MATRIX_CMD_CHECKSUM_EN
                        csum <= csum ^ in_data;
`else
                        if (last_elem) b_valid <= 1'b1;
`endif
                    end
`ifdef MATRIX_CMD_CHECKSUM_EN
                    ST_CHK: begin
                        if (in_data == csum) begin
                            if (chk_b) b_valid <= 1'b1;
                            else       a_valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_cmd_loader.sv
// Self-checking bench for matrix_cmd_loader (DIM = 2). A byte-stream model
// tracks what the loader must hold after every accepted byte; a compare
// process checks all outputs against it each cycle. Build option:
// MATRIX_CMD_CHECKSUM_EN (bench appends checksum bytes and runs the
// checksum scenarios).
module tb_matrix_cmd_loader;

    localparam int unsigned DIM = 2;
    localparam int unsigned N   = DIM * DIM;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op_busy = 1'b0;
    logic [8*N-1:0] mat_a, mat_b;
    logic        a_valid, b_valid, op_start, err;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit started = 0;

    matrix_cmd_loader #(.DIM(DIM)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .op_busy(op_busy), .mat_a(mat_a), .mat_b(mat_b),
        .a_valid(a_valid), .b_valid(b_valid), .op_start(op_start), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = waiting for opcode, 1 = collecting A, 2 = collecting B,
    //       3 = waiting for checksum byte
    int          m_mode = 0;
    int          m_idx = 0;
    logic [7:0]  m_a[N];
    logic [7:0]  m_b[N];
    logic [7:0]  m_sum = 8'h00;
    bit          m_sum_b = 0;
    bit          m_av = 0, m_bv = 0, m_err = 0, m_start = 0;

    function automatic logic [8*N-1:0] pack(input logic [7:0] e[N]);
        logic [8*N-1:0] v;
        for (int k = 0; k < N; k++) v[8*k +: 8] = e[k];
        return v;
    endfunction

    always @(posedge clk) begin
        bit go;
        logic [7:0] b;
        started = 1;
        go = 0;
        if (rst) begin
            m_mode = 0; m_idx = 0; m_sum = 8'h00;
            for (int k = 0; k < N; k++) begin m_a[k] = 8'h00; m_b[k] = 8'h00; end
            m_av = 0; m_bv = 0; m_err = 0; m_start = 0;
        end else begin
            if (in_valid && !op_busy && !m_start) begin
                b = in_data;
                if (m_mode == 0) begin
                    if (b == 8'hCA)      begin m_av = 0; m_mode = 1; m_idx = 0; m_sum = 8'h00; end
                    else if (b == 8'hCB) begin m_bv = 0; m_mode = 2; m_idx = 0; m_sum = 8'h00; end
                    else if (b == 8'hBB) begin if (m_av && m_bv) go = 1; else m_err = 1; end
                    else if (b == 8'hEE) begin
                        for (int k = 0; k < N; k++) begin m_a[k] = 8'h00; m_b[k] = 8'h00; end
                        m_av = 0; m_bv = 0; m_err = 0;
                    end else m_err = 1;
                end else if (m_mode == 1 || m_mode == 2) begin
                    if (m_mode == 1) m_a[m_idx] = b; else m_b[m_idx] = b;
                    m_sum = m_sum ^ b;
                    m_idx++;
                    if (m_idx == N) begin
`ifdef MATRIX_CMD_CHECKSUM_EN
                        m_sum_b = (m_mode == 2);
                        m_mode = 3;
`else
                        if (m_mode == 1) m_av = 1; else m_bv = 1;
                        m_mode = 0;
`endif
                    end
                end else begin
                    if (b == m_sum) begin if (m_sum_b) m_bv = 1; else m_av = 1; end
                    else m_err = 1;
                    m_mode = 0;
                end
            end
            m_start = go;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            check("mat_a", mat_a, pack(m_a));
            check("mat_b", mat_b, pack(m_b));
            check("flags{av,bv,err,start,rdy}", {27'd0, a_valid, b_valid, err, op_start, in_ready},
                  {27'd0, m_av, m_bv, m_err, m_start, !rst && !op_busy && !m_start});
            if (op_start === 1'b1) pulses++;
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change 2 time units after a rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #2; end
    endtask

    task automatic send(input logic [7:0] b);
        logic r;
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk); #2;
            if (r === 1'b1) break;
            guard++;
            if (guard >= 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: byte %h not accepted, got no ready expected ready", b);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_csum(input logic [7:0] x);
`ifdef MATRIX_CMD_CHECKSUM_EN
        send(x);
`else
        if (x == 8'hFF) tick(0);
`endif
    endtask

    task automatic load(input logic [7:0] op, input logic [31:0] v);
        send(op);
        for (int k = 0; k < 4; k++) send(v[8*k +: 8]);
        send_csum(v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24]);
    endtask

    task automatic pulse_rst();
        rst = 1'b1; tick(1); rst = 1'b0;
    endtask

    initial begin
        tick(2);
        @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mat_a", mat_a, 32'h0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // load A
        load(8'hCA, 32'h04030201);
        @(negedge clk);
        check("loadA_mat_a", mat_a, 32'h04030201);
        check("loadA_a_valid", {31'd0, a_valid}, 32'd1);
        check("loadA_err", {31'd0, err}, 32'd0);
        @(posedge clk); #2;

        // load B, start twice
        load(8'hCB, 32'h14131211);
        send(8'hBB);
        @(negedge clk);
        check("start_pulse", {31'd0, op_start}, 32'd1);
        check("start_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #2;
        send(8'hBB);
        tick(2);
        check("start_count", pulses, 2);

        // start without B
        pulse_rst();
        load(8'hCA, 32'h04030201);
        send(8'hBB);
        tick(2);
        check("nostart_count", pulses, 2);
        check("nostart_err", {31'd0, err}, 32'd1);
        send(8'hEE);
        @(negedge clk);
        check("clear_err", {31'd0, err}, 32'd0);
        check("clear_valid", {30'd0, a_valid, b_valid}, 32'd0);
        check("clear_mat_a", mat_a, 32'h0);
        @(posedge clk); #2;

        // busy stall mid-load
        send(8'hCB);
        send(8'h05);
        op_busy = 1'b1; in_valid = 1'b1; in_data = 8'h06;
        tick(10);
        in_valid = 1'b0; op_busy = 1'b0;
        send(8'h06); send(8'h07); send(8'h08);
        send_csum(8'h0C);
        @(negedge clk);
        check("stall_mat_b", mat_b, 32'h08070605);
        check("stall_b_valid", {31'd0, b_valid}, 32'd1);
        @(posedge clk); #2;

        // reset mid-load
        send(8'hCA); send(8'h01); send(8'h02);
        pulse_rst();
        send(8'h03);
        @(negedge clk);
        check("rstmid_mat_a", mat_a, 32'h0);
        check("rstmid_err", {31'd0, err}, 32'd1);
        @(posedge clk); #2;

`ifdef MATRIX_CMD_CHECKSUM_EN
        send(8'hEE);
        send(8'hCA); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h04);
        @(negedge clk);
        check("csum_ok_valid", {31'd0, a_valid}, 32'd1);
        check("csum_ok_err", {31'd0, err}, 32'd0);
        @(posedge clk); #2;
        send(8'hCA); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
        @(negedge clk);
        check("csum_bad_valid", {31'd0, a_valid}, 32'd0);
        check("csum_bad_err", {31'd0, err}, 32'd1);
        check("csum_bad_mat_a", mat_a, 32'h04030201);
        @(posedge clk); #2;
`endif

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_cmd_loader.md
# matrix_cmd_loader

Byte-stream command front end for the `MatrixMath` core. It accepts an 8-bit command/operand stream over a valid/ready handshake and decodes the opcodes `0xCA`, `0xCB`, `0xBB` and `0xEE`. It assembles operand matrices A and B into flat registers and issues a single-cycle start pulse to the downstream `MatrixMath` stage. The core's busy signal back-pressures the stream, so operands are never modified during an operation.

## Interface
Parameters:
- `DIM`, default 2: matrix dimension. Elements per matrix `N = DIM*DIM`. Element width is fixed at 8 bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_data` in 8: command or operand byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: byte is accepted on a rising edge when `in_valid & in_ready`.
- `op_busy` in 1: `MatrixMath` is busy.
- `mat_a` out `8*N`: matrix A. Element k (row-major, `k = r*DIM+c`) sits at bits `[8k+7:8k]`.
- `mat_b` out `8*N`: matrix B, same layout as `mat_a`.
- `a_valid` / `b_valid` out 1: matrix fully loaded.
- `op_start` out 1: one-cycle start pulse to `MatrixMath`.
- `err` out 1: sticky protocol error.

## Operation
- States:
  - `IDLE`: the next accepted byte is an opcode.
  - `LOAD_A` / `LOAD_B`: receiving N element bytes.
  - `CHK`: checksum byte; exists only with the macro defined.
  - `START`.
- Opcodes accepted in `IDLE`:
  - `0xCA`: clear `a_valid`, clear the element counter, go to `LOAD_A`.
  - `0xCB`: same as `0xCA`, for B.
  - `0xBB`: if `a_valid & b_valid`, go to `START`. Otherwise set `err` and stay in `IDLE`.
  - `0xEE`: zero `mat_a`/`mat_b`, clear both valid flags and `err`, stay in `IDLE`.
  - Any other byte: set `err`, drop the byte, stay in `IDLE`.
- `LOAD_x`:
  - Each accepted byte is written to element `cnt`, then `cnt` increments.
  - On the Nth byte: set `x_valid` and return to `IDLE`. With the macro defined, go to `CHK` instead.
  - Operand bytes are never decoded as opcodes. A byte of `0xCA` inside a load is data.
- `START`:
  - `op_start = 1` for exactly this one cycle.
  - Return to `IDLE` unconditionally.
  - Valid flags and matrices are retained, so `0xBB` may be repeated without reloading.
- `in_ready = !rst & !op_busy & (state != START)`.
- Downstream contract: `MatrixMath` raises `op_busy` in the cycle after it samples `op_start`. This guarantees no byte is accepted while the core is busy.
- `err` stays set until `0xEE` or `rst`. It never blocks further commands.

## Timing
- Reset: state `IDLE`, `cnt = 0`. The following are 0: `mat_a`, `mat_b`, `a_valid`, `b_valid`, `op_start`, `err`.
- `in_ready` is 0 while `rst` is high.
- Reset mid-load discards the partial matrix. The first byte accepted after reset is decoded as an opcode.
- Load latency: `x_valid` is 1 in the cycle after the final element byte (or checksum byte) is accepted.
- Start latency: `op_start` is 1 in the cycle after `0xBB` is accepted. `in_ready` is 0 in that same cycle.
- `op_busy` rising mid-load stalls the load. Progress is held with no loss, and the load resumes when `op_busy` falls.
- All outputs except `in_ready` are registered.

## Configuration
- `MATRIX_CMD_CHECKSUM_EN` defined:
  - Each load is followed by one checksum byte equal to the XOR of the N element bytes.
  - Match: set `x_valid`.
  - Mismatch: `x_valid` stays 0, `err` is set, and the matrix contents are left as received.
  - Both cases return to `IDLE`.
- Macro undefined:
  - No `CHK` state and no checksum register.
  - `x_valid` is set directly after the Nth byte.

## Structure
- Shared package `matrix_pkg` holds:
  - Opcode constants `OP_LOAD_A = 8'hCA`, `OP_LOAD_B = 8'hCB`, `OP_START = 8'hBB`, `OP_CLEAR = 8'hEE`.
  - The loader state enum.
  - The element width constant (8).
- No sub-module. The checksum is an inline 8-bit XOR accumulator cleared on each load opcode.

## Test plan
All scenarios use `DIM = 2`.
- Reset, then `CA 01 02 03 04` -> `mat_a = 32'h04030201`. `a_valid` rises one cycle after `04` is accepted. `err = 0`.
- Load A and B, hold `op_busy = 0`, send `BB` -> `op_start` high for exactly one cycle. `in_ready = 0` in that cycle. A second `BB` gives a second pulse.
- After reset, `CA 01 02 03 04 BB` (B not loaded) -> no `op_start`, `err = 1`. Then `EE` -> `err = 0`, both valid flags 0, matrices 0.
- Send `CB 05`, then `op_busy = 1` for 10 cycles while `in_valid` is held -> `in_ready = 0` and no bytes are consumed. After release, `06 07 08` completes with `mat_b = 32'h08070605`.
- Send `CA 01 02`, pulse `rst`, then send `03` -> matrices and flags are 0, and `03` is decoded as an unknown opcode, giving `err = 1`.
- With `MATRIX_CMD_CHECKSUM_EN`:
  - `CA 01 02 03 04 04` -> `a_valid = 1`.
  - `CA 01 02 03 04 05` -> `a_valid = 0`, `err = 1`.
